// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter sharing one combinational fp_addsub among NREQ clients.
// One operation in flight: IDLE -> ISSUE -> RESP, minimum 3 cycles each.
module fp_addsub_arbiter #(
   parameter int NREQ  = 4,
   parameter int SEL_W = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*32-1:0]   req_a,
   input  logic [NREQ*32-1:0]   req_b,
   input  logic [NREQ-1:0]      req_sub,
   output logic [31:0]          fpu_a,
   output logic [31:0]          fpu_b,
   output logic                 fpu_sub,
   input  logic [31:0]          fpu_result,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [31:0]          rsp_result,
   output logic [SEL_W-1:0]     grant_id,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t           state;
   state_t           state_nx;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] winner;
   logic [SEL_W-1:0] idx;
   logic             found;
   logic [31:0]      sel_a;
   logic [31:0]      sel_b;
   logic             sel_sub;

   // Scan from rr_ptr upward; index wraps naturally since NREQ == 2**SEL_W.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = rr_ptr + SEL_W'(k);
         if (!found && req_valid[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_sub = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (winner == SEL_W'(k)) begin
            sel_a   = req_a[32*k +: 32];
            sel_b   = req_b[32*k +: 32];
            sel_sub = req_sub[k];
         end
      end
   end

   always_comb begin
      state_nx  = state;
      req_ready = '0;
      rsp_valid = '0;
      case (state)
         IDLE: begin
            if (found) begin
               req_ready[winner] = 1'b1;
               state_nx          = ISSUE;
            end
         end
         ISSUE: state_nx = RESP;
         RESP: begin
            rsp_valid[grant_id] = 1'b1;
            if (rsp_ready[grant_id]) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         grant_id   <= '0;
         fpu_a      <= '0;
         fpu_b      <= '0;
         fpu_sub    <= 1'b0;
         rsp_result <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && found) begin
            fpu_a    <= sel_a;
            fpu_b    <= sel_b;
            fpu_sub  <= sel_sub;
            grant_id <= winner;
            rr_ptr   <= winner + SEL_W'(1);
         end
         if (state == ISSUE) rsp_result <= fpu_result;
      end
   end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Bench for fp_addsub_arbiter: directed vectors, queue scoreboard, stub fp_addsub.
// The stub returns hand-computed FP32 results for a small table of operand pairs.
module tb_fp_addsub_arbiter;

   localparam int NREQ  = 4;
   localparam int SEL_W = 2;

   // 1.5+2.25=3.75, 5-1=4, 1+1=2, 2-0.5=1.5
   localparam logic [31:0] VA [4] = '{32'h3FC00000, 32'h40A00000,
                                      32'h3F800000, 32'h40000000};
   localparam logic [31:0] VB [4] = '{32'h40100000, 32'h3F800000,
                                      32'h3F800000, 32'h3F000000};
   localparam logic [31:0] VR [4] = '{32'h40700000, 32'h40800000,
                                      32'h40000000, 32'h3FC00000};
   localparam logic [3:0]  VS     = 4'b1010;

   logic                 clk;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*32-1:0]   req_a;
   logic [NREQ*32-1:0]   req_b;
   logic [NREQ-1:0]      req_sub;
   logic [31:0]          fpu_a;
   logic [31:0]          fpu_b;
   logic                 fpu_sub;
   logic [31:0]          fpu_result;
   logic [NREQ-1:0]      rsp_valid;
   logic [NREQ-1:0]      rsp_ready;
   logic [31:0]          rsp_result;
   logic [SEL_W-1:0]     grant_id;
   logic                 busy;

   typedef struct {
      int          id;
      logic [31:0] res;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   fp_addsub_arbiter #(.NREQ(NREQ), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sub(fpu_sub),
      .fpu_result(fpu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .grant_id(grant_id), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      fpu_result = 32'hDEADBEEF;
      for (int k = 0; k < 4; k++)
         if (fpu_a == VA[k] && fpu_b == VB[k] && fpu_sub == VS[k])
            fpu_result = VR[k];
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation per response handshake.
   always @(negedge clk) begin
      if (rst_n && (rsp_valid & rsp_ready) != '0) begin
         if (q.size() == 0) begin
            check("unexpected_rsp", 32'(rsp_valid), 32'h0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
            check("rsp_result", rsp_result, e.res);
         end
      end
   end

   task automatic set_req(input int i, input int k);
      req_a[32*i +: 32] = VA[k];
      req_b[32*i +: 32] = VB[k];
      req_sub[i]        = VS[k];
      req_valid[i]      = 1'b1;
   endtask

   task automatic wait_grant(input string name, input int id);
      bit seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (req_ready != '0) seen = 1;
      end
      check(name, 32'(req_ready), 32'(1) << id);
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int n = 0; n < 30 && !done; n++) begin
         @(negedge clk);
         if (!busy) done = 1;
      end
      check("idle_timeout", 32'(done), 32'h1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_grant_id", 32'(grant_id), 32'h0);
      check("rst_fpu_a", fpu_a, 32'h0);
      check("rst_rsp_result", rsp_result, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic issue_one(input int i, input int k);
      set_req(i, k);
      @(negedge clk);
      check("ready_same_cycle", 32'(req_ready), 32'(1) << i);
      q.push_back('{i, VR[k]});
      @(posedge clk);
      #1 req_valid[i] = 1'b0;
      @(negedge clk);
      check("issue_busy", 32'(busy), 32'h1);
      check("issue_no_rsp", 32'(rsp_valid), 32'h0);
      check("grant_id", 32'(grant_id), 32'(i));
      check("fpu_a", fpu_a, VA[k]);
      @(negedge clk);
      check("rsp_latency", 32'(rsp_valid), 32'(1) << i);
      wait_idle();
   endtask

   initial begin
      int prev;
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_sub   = '0;
      rsp_ready = '1;
      do_reset();

      issue_one(1, 0);
      issue_one(2, 1);

      // all four at once from reset
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, i);
      prev = 0;
      for (int j = 0; j < 4; j++) begin
         wait_grant("rr_all_order", j);
         q.push_back('{j, VR[j]});
         if (j > 0) check("rr_spacing", 32'(cyc - prev), 32'd3);
         prev = cyc;
         @(posedge clk);
         #1 req_valid[j] = 1'b0;
      end
      wait_idle();

      // req0 and req2 held continuously
      set_req(0, 0);
      set_req(2, 2);
      for (int j = 0; j < 4; j++) begin
         int id;
         id = (j % 2 == 0) ? 0 : 2;
         wait_grant("rr_pair_order", id);
         q.push_back('{id, VR[id]});
      end
      @(posedge clk);
      #1 req_valid = '0;
      wait_idle();

      // response back-pressure; non-granted rsp_ready lines are high
      rsp_ready = 4'b0111;
      set_req(3, 3);
      @(negedge clk);
      check("bp_ready", 32'(req_ready), 32'h8);
      q.push_back('{3, VR[3]});
      @(posedge clk);
      #1 req_valid[3] = 1'b0;
      set_req(0, 0);
      @(negedge clk);
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         check("bp_rsp_valid", 32'(rsp_valid), 32'h8);
         check("bp_rsp_result", rsp_result, 32'h3FC00000);
         check("bp_busy", 32'(busy), 32'h1);
         check("bp_no_ready", 32'(req_ready), 32'h0);
      end
      @(posedge clk);
      #1 rsp_ready = '1;
      wait_grant("bp_then_req0", 0);
      q.push_back('{0, VR[0]});
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      wait_idle();

      // reset while in ISSUE
      set_req(1, 0);
      @(negedge clk);
      check("pre_rst_ready", 32'(req_ready), 32'h2);
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("mid_rst_grant_id", 32'(grant_id), 32'h0);
      check("mid_rst_fpu_a", fpu_a, 32'h0);
      check("mid_rst_fpu_b", fpu_b, 32'h0);
      check("mid_rst_fpu_sub", 32'(fpu_sub), 32'h0);
      check("mid_rst_rsp_result", rsp_result, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         check("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
      end
      @(posedge clk);
      #1;
      set_req(3, 3);
      set_req(1, 1);
      wait_grant("post_rst_ptr0", 1);
      q.push_back('{1, VR[1]});
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      wait_grant("post_rst_req3", 3);
      q.push_back('{3, VR[3]});
      @(posedge clk);
      #1 req_valid[3] = 1'b0;
      wait_idle();

      check("queue_drained", 32'(q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
